// File: rtl/if_id_buffer.sv
// Fetch-to-decode skid FIFO: buffers up to DEPTH {instr, pc} beats and flushes on branch/jump.
// Optional stall/flush performance counters are compiled in with IF_ID_PERF_EN.
module if_id_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            i_if_instr,
  input  logic [63:0]            i_if_pc,
  input  logic                   i_if_valid,
  output logic                   o_if_ready,
  input  logic                   i_flush,
  output logic [31:0]            o_id_instr,
  output logic [63:0]            o_id_pc,
  output logic                   o_id_valid,
  input  logic                   i_id_ready,
  output logic [$clog2(DEPTH):0] o_count
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]            o_stall_cnt,
  output logic [31:0]            o_flush_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

  logic [31:0]     instr_mem_q [DEPTH];
  logic [63:0]     pc_mem_q    [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Handshake outputs depend on registered occupancy only.
  assign o_if_ready = (count_q != CountFull);
  assign o_id_valid = (count_q != '0);
  assign o_count    = count_q;

  assign push = i_if_valid & o_if_ready & ~i_flush;
  assign pop  = o_id_valid & i_id_ready & ~i_flush;

  always_comb begin
    o_id_instr = NOP_INSTR;
    o_id_pc    = '0;
    if (o_id_valid) begin
      o_id_instr = instr_mem_q[rd_ptr_q];
      o_id_pc    = pc_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem_q[wr_ptr_q] <= i_if_instr;
      pc_mem_q[wr_ptr_q]    <= i_if_pc;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_if_valid && !o_if_ready && !i_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // Count only flushes that threw away a buffered or incoming beat.
    if (i_flush && (o_id_valid || i_if_valid) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  // Performance counters compiled out; core behaviour is unchanged.
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: driver queues accepted beats, monitor checks decode output.
module tb_if_id_buffer;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_if_instr = '0;
  logic [63:0] i_if_pc = '0;
  logic        i_if_valid = 1'b0;
  logic        o_if_ready;
  logic        i_flush = 1'b0;
  logic [31:0] o_id_instr;
  logic [63:0] o_id_pc;
  logic        o_id_valid;
  logic        i_id_ready = 1'b0;
  logic [$clog2(DEPTH):0] o_count;
`ifdef IF_ID_PERF_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
  int unsigned stall_m = 0, flush_m = 0;
`endif

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_if_instr (i_if_instr),
    .i_if_pc    (i_if_pc),
    .i_if_valid (i_if_valid),
    .o_if_ready (o_if_ready),
    .i_flush    (i_flush),
    .o_id_instr (o_id_instr),
    .o_id_pc    (o_id_pc),
    .o_id_valid (o_id_valid),
    .i_id_ready (i_id_ready),
    .o_count    (o_count)
`ifdef IF_ID_PERF_EN
    ,
    .o_stall_cnt(o_stall_cnt),
    .o_flush_cnt(o_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference contents of the buffer, oldest first: {instr, pc}.
  logic [95:0] exp_q [$];
  bit          clr_pend = 1'b0;
  bit          armed = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, entered at posedge+#1: check state, drive inputs, update the model.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                       input bit rdy, input bit fl, input bit r);
    int sz;
    if (clr_pend) begin
      exp_q.delete();
      clr_pend = 1'b0;
    end
    sz = exp_q.size();
    chk("if_ready", 64'(o_if_ready), 64'(sz != DEPTH));
    chk("id_valid", 64'(o_id_valid), 64'(sz != 0));
    chk("count", 64'(o_count), 64'(sz));
    if (sz == 0) begin
      chk("nop_instr", 64'(o_id_instr), 64'(NOP));
      chk("nop_pc", o_id_pc, 64'h0);
    end
`ifdef IF_ID_PERF_EN
    chk("stall_cnt", 64'(o_stall_cnt), 64'(stall_m));
    chk("flush_cnt", 64'(o_flush_cnt), 64'(flush_m));
`endif
    i_if_valid = v;
    i_if_instr = ins;
    i_if_pc    = pc;
    i_id_ready = rdy;
    i_flush    = fl;
    rst        = r;
    if (r) begin
      clr_pend = 1'b1;
`ifdef IF_ID_PERF_EN
      stall_m = 0;
      flush_m = 0;
`endif
    end else begin
`ifdef IF_ID_PERF_EN
      if (v && sz == DEPTH && !fl) stall_m++;
      if (fl && (sz != 0 || v)) flush_m++;
`endif
      if (fl) clr_pend = 1'b1;
      else if (v && sz != DEPTH) exp_q.push_back({ins, pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 32'h0, 64'h0, rdy, 1'b0, 1'b0);
  endtask

  // Monitor: whenever a beat is presented, it must be the oldest expected one.
  always @(negedge clk) begin
    if (armed && !rst && o_id_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 64'(o_id_valid), 64'h0);
      end else begin
        chk("id_instr", 64'(o_id_instr), 64'(exp_q[0][95:64]));
        chk("id_pc", o_id_pc, exp_q[0][63:0]);
        if (i_id_ready && !i_flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    // Reset, then a single beat.
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    cycle(1'b1, 32'h0050_0093, 64'h100, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    // Fill with decode stalled, then drain.
    cycle(1'b1, 32'hA100, 64'h100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA104, 64'h104, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA108, 64'h108, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA108, 64'h108, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hA108, 64'h108, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hA108, 64'h108, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    // Steady stream.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 32'hB000 + 32'(k), 64'h100 + 64'(4 * k), 1'b1, 1'b0, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    // Flush with occupancy 2 and an incoming beat.
    cycle(1'b1, 32'hC300, 64'h300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC304, 64'h304, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC110, 64'h110, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'hC200, 64'h200, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    // Reset mid-operation together with valid and flush.
    cycle(1'b1, 32'hD400, 64'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD404, 64'h404, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD408, 64'h408, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
`ifdef IF_ID_PERF_EN
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hE500, 64'h500, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hE504, 64'h504, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 32'hE508, 64'h508, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hE508, 64'h508, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("stall_cnt_5", 64'(o_stall_cnt), 64'd5);
    chk("flush_cnt_1", 64'(o_flush_cnt), 64'd1);
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("flush_cnt_empty", 64'(o_flush_cnt), 64'd1);
`endif
    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom % 4) != 0, $urandom, {$urandom, $urandom}, ($urandom % 3) != 0,
            ($urandom % 16) == 0, ($urandom % 64) == 0);
    end
    for (int n = 0; n < 4; n++) idle(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
